// File: rtl/switch_debounce_if.sv
// Signal bundle between the raw switch pins, the debouncer and downstream logic.
// toggle_out is present only when SWITCH_DEBOUNCE_TOGGLE_EN is defined.
interface switch_debounce_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] raw_in;
  logic [CHANNELS-1:0] level_out;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic                busy;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  logic [CHANNELS-1:0] toggle_out;

  modport master (
    output raw_in,
    input  level_out, rise_pulse, fall_pulse, busy, toggle_out
  );
  modport slave (
    input  raw_in,
    output level_out, rise_pulse, fall_pulse, busy, toggle_out
  );
`else
  modport master (
    output raw_in,
    input  level_out, rise_pulse, fall_pulse, busy
  );
  modport slave (
    input  raw_in,
    output level_out, rise_pulse, fall_pulse, busy
  );
`endif
endinterface

// File: rtl/switch_debounce.sv
// Per-channel synchroniser plus STABLE/COUNT debounce FSM with registered edge pulses.
// Optional on/off latch output enabled by defining SWITCH_DEBOUNCE_TOGGLE_EN.
module switch_debounce #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int SYNC_STAGES     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  switch_debounce_if.slave sw
);

  typedef enum logic {STABLE = 1'b0, COUNT = 1'b1} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CHANNELS-1:0] s;

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] accept;

  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] rise_q,  rise_d;
  logic [CHANNELS-1:0] fall_q,  fall_d;
  logic                busy_q,  busy_d;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  logic [CHANNELS-1:0] toggle_q, toggle_d;
`endif

  always_comb begin
    sync_d[0] = sw.raw_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // State register: synchroniser, FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      busy_q   <= 1'b0;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
      toggle_q <= '0;
`endif
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
      toggle_q <= toggle_d;
`endif
    end
  end

  // Next state: any sample agreeing with the current level aborts the count.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      accept[i]  = 1'b0;
      case (state_q[i])
        STABLE: begin
          if (s[i] != level_q[i]) begin
            state_d[i] = COUNT;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = '0;
          end
        end
        COUNT: begin
          if (s[i] == level_q[i]) begin
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            accept[i]  = 1'b1;
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Outputs: pulses fire on the same edge that updates the level.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    busy_d  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (accept[i]) begin
        level_d[i] = s[i];
        rise_d[i]  = s[i];
        fall_d[i]  = ~s[i];
      end
      busy_d = busy_d | (state_d[i] == COUNT);
    end
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    toggle_d = toggle_q ^ rise_d;
`endif
  end

  assign sw.level_out  = level_q;
  assign sw.rise_pulse = rise_q;
  assign sw.fall_pulse = fall_q;
  assign sw.busy       = busy_q;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  assign sw.toggle_out = toggle_q;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=8, SYNC_STAGES=2, CHANNELS=4.
module tb_switch_debounce;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  switch_debounce_if #(.CHANNELS(4)) sw_if ();

  switch_debounce #(
    .CHANNELS        (4),
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (20),
    .SYNC_STAGES     (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic seen_rise1, seen_level1, seen_busy;

  initial begin
    sw_if.raw_in = 4'hF;
    rst_n        = 1'b0;

    // reset held with all inputs high
    for (int c = 0; c < 3; c++) begin
      tick(1);
      check("rst_level", sw_if.level_out, 4'h0);
      check("rst_rise",  sw_if.rise_pulse, 4'h0);
      check("rst_fall",  sw_if.fall_pulse, 4'h0);
      check("rst_busy",  sw_if.busy, 1'b0);
    end
    rst_n = 1'b1;
    tick(9);
    check("post_rst_level_k8", sw_if.level_out, 4'h0);
    check("post_rst_busy_k8",  sw_if.busy, 1'b1);
    tick(1);
    check("post_rst_level_k9", sw_if.level_out, 4'hF);
    check("post_rst_rise_k9",  sw_if.rise_pulse, 4'hF);
    check("post_rst_busy_k9",  sw_if.busy, 1'b0);
    tick(1);
    check("post_rst_rise_k10", sw_if.rise_pulse, 4'h0);

    // release ch2
    sw_if.raw_in = 4'hB;
    tick(9);
    check("rel2_level_k8", sw_if.level_out, 4'hF);
    check("rel2_fall_k8",  sw_if.fall_pulse, 4'h0);
    tick(1);
    check("rel2_level_k9", sw_if.level_out, 4'hB);
    check("rel2_fall_k9",  sw_if.fall_pulse, 4'h4);
    check("rel2_rise_k9",  sw_if.rise_pulse, 4'h0);
    tick(1);
    check("rel2_fall_k10", sw_if.fall_pulse, 4'h0);

    // all low
    sw_if.raw_in = 4'h0;
    tick(10);
    check("all_low_level", sw_if.level_out, 4'h0);
    check("all_low_fall",  sw_if.fall_pulse, 4'hB);
    tick(1);

    // clean press ch0
    sw_if.raw_in = 4'h1;
    tick(1);
    check("press0_busy_k0", sw_if.busy, 1'b0);
    tick(1);
    check("press0_busy_k1", sw_if.busy, 1'b0);
    tick(1);
    check("press0_busy_k2", sw_if.busy, 1'b1);
    tick(6);
    check("press0_level_k8", sw_if.level_out, 4'h0);
    check("press0_rise_k8",  sw_if.rise_pulse, 4'h0);
    tick(1);
    check("press0_level_k9", sw_if.level_out, 4'h1);
    check("press0_rise_k9",  sw_if.rise_pulse, 4'h1);
    check("press0_busy_k9",  sw_if.busy, 1'b0);
    tick(1);
    check("press0_rise_k10", sw_if.rise_pulse, 4'h0);
    check("press0_busy_k10", sw_if.busy, 1'b0);

    // bounce on ch1: 5 high, 1 low, 5 high, then low
    seen_rise1  = 1'b0;
    seen_level1 = 1'b0;
    seen_busy   = 1'b0;
    for (int j = 0; j < 11; j++) begin
      sw_if.raw_in = {2'b00, (j != 5), 1'b1};
      tick(1);
      seen_rise1  |= sw_if.rise_pulse[1];
      seen_level1 |= sw_if.level_out[1];
      seen_busy   |= sw_if.busy;
    end
    sw_if.raw_in = 4'h1;
    for (int j = 0; j < 12; j++) begin
      tick(1);
      seen_rise1  |= sw_if.rise_pulse[1];
      seen_level1 |= sw_if.level_out[1];
    end
    check("bounce_rise1",  seen_rise1, 1'b0);
    check("bounce_level1", seen_level1, 1'b0);
    check("bounce_busy_seen", seen_busy, 1'b1);
    check("bounce_busy_end",  sw_if.busy, 1'b0);
    check("bounce_level_all", sw_if.level_out, 4'h1);

    // release ch0
    sw_if.raw_in = 4'h0;
    tick(10);
    check("rel0_level", sw_if.level_out, 4'h0);
    check("rel0_fall",  sw_if.fall_pulse, 4'h1);
    tick(1);

    // simultaneous ch0+ch3 with reset mid-count
    sw_if.raw_in = 4'h9;
    tick(6);
    check("sim_busy_mid",  sw_if.busy, 1'b1);
    check("sim_rise_mid",  sw_if.rise_pulse, 4'h0);
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick(1);
      check("sim_rst_level", sw_if.level_out, 4'h0);
      check("sim_rst_rise",  sw_if.rise_pulse, 4'h0);
      check("sim_rst_busy",  sw_if.busy, 1'b0);
    end
    rst_n = 1'b1;
    tick(9);
    check("sim_level_k8", sw_if.level_out, 4'h0);
    check("sim_rise_k8",  sw_if.rise_pulse, 4'h0);
    tick(1);
    check("sim_level_k9", sw_if.level_out, 4'h9);
    check("sim_rise_k9",  sw_if.rise_pulse, 4'h9);
    tick(1);
    check("sim_rise_k10", sw_if.rise_pulse, 4'h0);

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    // toggle latch on ch0
    sw_if.raw_in = 4'h0;
    rst_n = 1'b0;
    tick(2);
    check("tog_rst", sw_if.toggle_out, 4'h0);
    rst_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      sw_if.raw_in = 4'h1;
      tick(10);
      check("tog_press_rise", sw_if.rise_pulse, 4'h1);
      check("tog_press", sw_if.toggle_out, (p % 2 == 0) ? 4'h1 : 4'h0);
      sw_if.raw_in = 4'h0;
      tick(11);
      check("tog_release", sw_if.toggle_out, (p % 2 == 0) ? 4'h1 : 4'h0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
